// File: rtl/mem_access_unit.sv
// Memory-side stage: turns control strobes into a req/ack bus access.
// Holds IR/MDR and stalls control while a transaction is outstanding.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IorD,
    input  logic              IRenable,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] IR,
    output logic [4:0]        OPcode,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              BusErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic              r_stall;
    logic              r_buserr;
    logic [TO_W-1:0]   r_cnt;
    logic              r_dst_ir;
    logic [3:0]        r_tag;
    logic [3:0]        r_last_tag;

    logic [3:0]        w_tag;
    logic              w_req;
    logic              w_start;
    logic [TO_W-1:0]   w_cnt_nxt;
    logic              w_timeout;

    assign w_tag     = {MemRead, MemWrite, IorD, IRenable};
    assign w_req     = MemRead | MemWrite;
    assign w_start   = (r_state == S_IDLE) && w_req
                       && (w_tag != r_last_tag);
    assign w_cnt_nxt = r_cnt + TO_W'(1);
    // ack has priority over an expiring counter
    assign w_timeout = !mem_ack && (w_cnt_nxt == TO_LIM);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ir       <= '0;
            r_mdr      <= '0;
            r_stall    <= 1'b0;
            r_buserr   <= 1'b0;
            r_cnt      <= '0;
            r_dst_ir   <= 1'b0;
            r_tag      <= '0;
            r_last_tag <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // an all-zero tag re-arms a repeat of the last access
                    if (w_tag == 4'b0000) begin
                        r_last_tag <= '0;
                    end
                    if (w_start) begin
                        r_addr   <= IorD ? ALUOut : PC;
                        r_we     <= MemWrite;
                        r_wdata  <= WriteData;
                        r_dst_ir <= IRenable;
                        r_tag    <= w_tag;
                        r_req    <= 1'b1;
                        r_stall  <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_nxt;
                    if (mem_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_we) begin
                            if (r_dst_ir) begin
                                r_ir <= mem_rdata;
                            end else begin
                                r_mdr <= mem_rdata;
                            end
                        end
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_we     <= 1'b0;
                        r_buserr <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_stall    <= 1'b0;
                    r_last_tag <= r_tag;
                end
                default: begin
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign IR        = r_ir;
    assign OPcode    = r_ir[DATA_W-1 -: 5];
    assign MDR       = r_mdr;
    assign Stall     = r_stall;
    assign BusErr    = r_buserr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: bus responder with scoreboard of expected
// transactions, plus per-scenario register and handshake checks.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        IRenable;
    logic [15:0] PC;
    logic [15:0] ALUOut;
    logic [15:0] WriteData;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] IR;
    logic [4:0]  OPcode;
    logic [15:0] MDR;
    logic        Stall;
    logic        BusErr;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_req = 0;
    logic prev_req = 1'b0;
    logic ack_en = 1'b0;
    logic ack_force = 1'b0;
    int   ack_delay = 0;
    int   rcnt = 0;

    mem_access_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .TO_W   (8),
        .TIMEOUT(4)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .IRenable (IRenable),
        .PC       (PC),
        .ALUOut   (ALUOut),
        .WriteData(WriteData),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .IR       (IR),
        .OPcode   (OPcode),
        .MDR      (MDR),
        .Stall    (Stall),
        .BusErr   (BusErr)
    );

    initial forever #5 CLK = ~CLK;

    // Bus responder: acks ack_delay cycles after the request rises and
    // checks the completing transaction against the scoreboard.
    initial begin
        txn_t e;
        mem_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_force) begin
                mem_ack = 1'b1;
            end else if (ack_en && mem_req === 1'b1) begin
                if (rcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL bus_txn: got we=%b addr=%h wdata=%h, required none",
                                 mem_we, mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr
                            || mem_wdata !== e.wdata) begin
                            n_fail++;
                            $display("FAIL bus_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata,
                                     e.we, e.addr, e.wdata);
                        end
                    end
                end else begin
                    mem_ack = 1'b0;
                end
                rcnt++;
            end else begin
                mem_ack = 1'b0;
                rcnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (mem_req === 1'b1 && !prev_req) n_req++;
        prev_req = (mem_req === 1'b1);
    end

    task automatic set_ctrl(input logic rd, input logic wr,
                            input logic iord, input logic iren);
        MemRead  = rd;
        MemWrite = wr;
        IorD     = iord;
        IRenable = iren;
    endtask

    task automatic test_reset;
        #1 Reset = 1'b1;
        repeat (2) @(negedge CLK);
        n_chk++;
        if ({mem_req, mem_we, Stall, BusErr} !== 4'b0000
            || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: req=%b we=%b stall=%b err=%b addr=%h wd=%h, required all 0",
                     mem_req, mem_we, Stall, BusErr, mem_addr, mem_wdata);
        end
        n_chk++;
        if (IR !== 16'h0 || MDR !== 16'h0 || OPcode !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_regs: IR=%h MDR=%h op=%b, required 0",
                     IR, MDR, OPcode);
        end
        Reset = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (mem_req !== 1'b0 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: req=%b stall=%b, required 0 0",
                     mem_req, Stall);
        end
    endtask

    task automatic test_fetch;
        int stall_n = 0;
        @(negedge CLK);
        WriteData = 16'h0000;
        PC        = 16'h0040;
        mem_rdata = 16'h4A21;
        ack_delay = 0;
        ack_en    = 1'b1;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(txn_t'{1'b0, 16'h0040, 16'h0000});
        @(negedge CLK);
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_issue: req=%b addr=%h we=%b, required 1 0040 0",
                     mem_req, mem_addr, mem_we);
        end
        if (Stall === 1'b1) stall_n++;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (Stall === 1'b1) stall_n++;
        end
        n_chk++;
        if (stall_n != 2) begin
            n_fail++;
            $display("FAIL fetch_stall: %0d cycles, required 2", stall_n);
        end
        n_chk++;
        if (IR !== 16'h4A21 || OPcode !== 5'b01001) begin
            n_fail++;
            $display("FAIL fetch_ir: IR=%h op=%b, required 4a21 01001",
                     IR, OPcode);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lw;
        int n_bad = 0;
        @(negedge CLK);
        PC        = 16'h0000;
        ALUOut    = 16'h1234;
        mem_rdata = 16'hBEEF;
        ack_delay = 3;
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(txn_t'{1'b0, 16'h1234, 16'h0000});
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || Stall !== 1'b1)
                n_bad++;
            ALUOut = 16'h5555;
        end
        n_chk++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL lw_hold: %0d unstable wait cycles, required 0",
                     n_bad);
        end
        repeat (4) @(negedge CLK);
        n_chk++;
        if (MDR !== 16'hBEEF || IR !== 16'h4A21) begin
            n_fail++;
            $display("FAIL lw_regs: MDR=%h IR=%h, required beef 4a21",
                     MDR, IR);
        end
        n_chk++;
        if (BusErr !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_ack_vs_timeout: BusErr=%b, required 0", BusErr);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int r0;
        @(negedge CLK);
        r0        = n_req;
        ALUOut    = 16'h0100;
        WriteData = 16'h00FF;
        PC        = 16'h0080;
        mem_rdata = 16'h1357;
        ack_delay = 0;
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(txn_t'{1'b1, 16'h0100, 16'h00FF});
        @(negedge CLK);
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(txn_t'{1'b0, 16'h0080, 16'h00FF});
        repeat (6) @(negedge CLK);
        n_chk++;
        if (n_req - r0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d requests, required 2", n_req - r0);
        end
        n_chk++;
        if (IR !== 16'h1357 || MDR !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL b2b_regs: IR=%h MDR=%h, required 1357 beef",
                     IR, MDR);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_write_wins;
        @(negedge CLK);
        ALUOut    = 16'h0110;
        WriteData = 16'hA5A5;
        mem_rdata = 16'hDEAD;
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(txn_t'{1'b1, 16'h0110, 16'hA5A5});
        repeat (5) @(negedge CLK);
        n_chk++;
        if (MDR !== 16'hBEEF || IR !== 16'h1357) begin
            n_fail++;
            $display("FAIL write_wins: MDR=%h IR=%h, required beef 1357",
                     MDR, IR);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_held;
        int r0;
        @(negedge CLK);
        r0        = n_req;
        ALUOut    = 16'h0200;
        mem_rdata = 16'h2468;
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(txn_t'{1'b0, 16'h0200, 16'hA5A5});
        repeat (6) @(negedge CLK);
        n_chk++;
        if (n_req - r0 != 1) begin
            n_fail++;
            $display("FAIL held_count: %0d requests, required 1", n_req - r0);
        end
        n_chk++;
        if (MDR !== 16'h2468) begin
            n_fail++;
            $display("FAIL held_mdr: MDR=%h, required 2468", MDR);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        int hi = 0;
        @(negedge CLK);
        ack_en = 1'b0;
        PC     = 16'h0300;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (mem_req === 1'b1) hi++;
        end
        n_chk++;
        if (hi != 4) begin
            n_fail++;
            $display("FAIL timeout_len: req high %0d cycles, required 4", hi);
        end
        n_chk++;
        if (BusErr !== 1'b1 || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag: BusErr=%b Stall=%b, required 1 0",
                     BusErr, Stall);
        end
        n_chk++;
        if (IR !== 16'h1357 || MDR !== 16'h2468) begin
            n_fail++;
            $display("FAIL timeout_regs: IR=%h MDR=%h, required 1357 2468",
                     IR, MDR);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        ack_en    = 1'b1;
        PC        = 16'h0310;
        mem_rdata = 16'h8001;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(txn_t'{1'b0, 16'h0310, 16'hA5A5});
        repeat (5) @(negedge CLK);
        n_chk++;
        if (IR !== 16'h8001 || BusErr !== 1'b1) begin
            n_fail++;
            $display("FAIL buserr_sticky: IR=%h BusErr=%b, required 8001 1",
                     IR, BusErr);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait;
        @(negedge CLK);
        ack_en = 1'b0;
        PC     = 16'h0400;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        n_chk++;
        if (mem_req !== 1'b1 || Stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: req=%b stall=%b, required 1 1",
                     mem_req, Stall);
        end
        #2 Reset = 1'b1;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || Stall !== 1'b0 || IR !== 16'h0
            || BusErr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: req=%b stall=%b IR=%h err=%b, required 0",
                     mem_req, Stall, IR, BusErr);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset     = 1'b0;
        mem_rdata = 16'hFFFF;
        ack_force = 1'b1;
        repeat (2) @(negedge CLK);
        ack_force = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (IR !== 16'h0 || MDR !== 16'h0 || mem_req !== 1'b0
            || Stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: IR=%h MDR=%h req=%b stall=%b, required 0",
                     IR, MDR, mem_req, Stall);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRenable  = 1'b0;
        PC        = 16'h0;
        ALUOut    = 16'h0;
        WriteData = 16'h0;
        mem_rdata = 16'h0;
        test_reset();
        test_fetch();
        test_lw();
        test_back_to_back();
        test_write_wins();
        test_held();
        test_timeout();
        test_reset_mid_wait();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
